// File: rtl/dict_shift_multi_if.sv
// Write-side and window-side signal bundle of the multi-lane sliding dictionary.
// There is no valid/ready pair. The dictionary takes the enabled lanes on every
// clock and never stalls the producer. o_full is a status flag only and does not
// gate writes.
interface dict_shift_multi_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int LANES      = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [LANES-1:0]            i_wr;
    logic [LANES*DATA_WIDTH-1:0] i_data;
    logic                        i_flush;
    logic [DEPTH*DATA_WIDTH-1:0] o_dict;
    logic [DEPTH-1:0]            o_valid;
    logic [CW-1:0]               o_count;
    logic                        o_full;
    logic                        o_ovf;

    // Producer side: drives the write lanes and the flush, and observes the window.
    modport master (
        output i_wr, i_data, i_flush,
        input  o_dict, o_valid, o_count, o_full, o_ovf
    );

    // Dictionary side.
    modport slave (
        input  i_wr, i_data, i_flush,
        output o_dict, o_valid, o_count, o_full, o_ovf
    );
endinterface

// File: rtl/dict_shift_multi.sv
// Multi-lane recency-ordered sliding dictionary. Entry 0 holds the newest word.
// Each cycle the enabled lanes are packed and shifted in at the front of the window.
// Older entries move back by the number of words written, and entries pushed past
// DEPTH are dropped.
module dict_shift_multi #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int LANES      = 2,
    parameter int OUT_REG    = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    dict_shift_multi_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = DEPTH * DATA_WIDTH;
    localparam int LW = LANES * DATA_WIDTH;

    logic [WW-1:0]    win_q, win_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic [LW-1:0]    comp;
    logic [DEPTH-1:0] base_vld;
    int               n;
    int               base;
    int               sum;

    // Pack the enabled lanes. The lowest enabled lane lands in the top slot
    // (LANES-1), the next enabled lane in the slot below it, and so on. The n used
    // slots then sit directly under the window in {window, comp}. A right shift by
    // (LANES-n) slots puts the highest enabled lane at entry 0.
    always_comb begin
        comp = '0;
        n    = 0;
        for (int k = 0; k < LANES; k++) begin
            if (bus.i_wr[k]) begin
                for (int s = 0; s < LANES; s++) begin
                    if (s == LANES - 1 - n) begin
                        comp[s*DATA_WIDTH +: DATA_WIDTH] = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                n = n + 1;
            end
        end
    end

    // Next window, valid map, occupancy and overflow. A flush clears the valid
    // bits and the count before this cycle's words are shifted in. Data words are
    // left in place because only the valid bits matter.
    always_comb begin
        base_vld = bus.i_flush ? '0 : vld_q;
        win_d    = WW'({win_q, comp} >> ((LANES - n) * DATA_WIDTH));
        vld_d    = DEPTH'({base_vld, {LANES{1'b1}}} >> (LANES - n));
        base     = bus.i_flush ? 0 : int'(cnt_q);
        sum      = base + n;
        ovf_d    = (sum > DEPTH);
        cnt_d    = ovf_d ? CW'(DEPTH) : CW'(sum);
        full_d   = (cnt_d == CW'(DEPTH));
    end

    // Window and status registers. Reset wipes the data words as well as the
    // valid bits.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            win_q  <= '0;
            vld_q  <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            win_q  <= win_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.o_count = cnt_q;
    assign bus.o_full  = full_q;
    assign bus.o_ovf   = ovf_q;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WW-1:0]    dict_q;
            logic [DEPTH-1:0] valid_q;

            // Extra stage on the window view only. Count and full stay one cycle
            // ahead so the match stage can size its search range early.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    dict_q  <= '0;
                    valid_q <= '0;
                end else begin
                    dict_q  <= win_q;
                    valid_q <= vld_q;
                end
            end

            assign bus.o_dict  = dict_q;
            assign bus.o_valid = valid_q;
        end else begin : g_out_direct
            assign bus.o_dict  = win_q;
            assign bus.o_valid = vld_q;
        end
    endgenerate
endmodule

// File: tb/tb_dict_shift_multi.sv
// Bench for dict_shift_multi (OUT_REG=1). A table of vectors carries
// hand-derived counts and entries. A behavioural window model feeds a queue of
// expected window snapshots, which are compared one cycle later against
// o_dict/o_valid.
module tb_dict_shift_multi;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LANES = 2;
    localparam int SW    = DEPTH * DW + DEPTH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dict_shift_multi_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LANES(LANES)) bus ();

    dict_shift_multi #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .LANES(LANES), .OUT_REG(1)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    // ---------------- reference model and scoreboard ----------------
    logic [DW-1:0]    m_win [DEPTH];
    logic [DEPTH-1:0] m_vld;
    int               m_cnt;
    logic             m_ovf;
    logic [SW-1:0]    exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] pack_model();
        logic [SW-1:0] s;
        s = '0;
        for (int e = 0; e < DEPTH; e++) s[e*DW +: DW] = m_win[e];
        s[DEPTH*DW +: DEPTH] = m_vld;
        return s;
    endfunction

    task automatic model_update(input logic rst, input logic flush, input logic [1:0] wr,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        logic [DW-1:0]    lanes [LANES];
        logic [DW-1:0]    lst   [LANES];
        logic [DW-1:0]    nw    [DEPTH];
        logic [DEPTH-1:0] bv, nv;
        int               n, bc;
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) m_win[e] = '0;
            m_vld = '0;
            m_cnt = 0;
            m_ovf = 1'b0;
            exp_q.delete();
            exp_q.push_back(pack_model());
            return;
        end
        lanes[0] = d0;
        lanes[1] = d1;
        n = 0;
        for (int k = LANES - 1; k >= 0; k--) begin
            lst[n] = '0;
            if (wr[k]) begin
                lst[n] = lanes[k];
                n++;
            end
        end
        bv = flush ? '0 : m_vld;
        bc = flush ? 0 : m_cnt;
        nv = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (e < n) begin
                nw[e] = lst[e];
                nv[e] = 1'b1;
            end else begin
                nw[e] = m_win[e-n];
                nv[e] = bv[e-n];
            end
        end
        for (int e = 0; e < DEPTH; e++) m_win[e] = nw[e];
        m_vld = nv;
        m_ovf = (bc + n > DEPTH);
        m_cnt = (bc + n > DEPTH) ? DEPTH : bc + n;
        exp_q.push_back(pack_model());
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic rst, input logic flush, input logic [1:0] wr,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        logic [SW-1:0] ex;
        reset       = rst;
        bus.i_flush = flush;
        bus.i_wr    = wr;
        bus.i_data  = {d1, d0};
        @(posedge clk);
        #1;
        model_update(rst, flush, wr, d0, d1);
        check("count", 64'(bus.o_count), 64'(m_cnt));
        check("full", 64'(bus.o_full), 64'(m_cnt == DEPTH));
        check("ovf", 64'(bus.o_ovf), 64'(m_ovf));
        if (rst) begin
            check("valid_after_reset", 64'(bus.o_valid), 64'(0));
            for (int e = 0; e < DEPTH; e++)
                check($sformatf("dict_after_reset[%0d]", e), 64'(bus.o_dict[e*DW +: DW]), 64'(0));
        end else if (exp_q.size() >= 2) begin
            ex = exp_q.pop_front();
            check("sb_valid", 64'(bus.o_valid), 64'(ex[DEPTH*DW +: DEPTH]));
            for (int e = 0; e < DEPTH; e++)
                if (ex[DEPTH*DW + e])
                    check($sformatf("sb_entry[%0d]", e), 64'(bus.o_dict[e*DW +: DW]), 64'(ex[e*DW +: DW]));
        end
    endtask

    // ---------------- vector table ----------------
    // chk: 0 = counts only, 1 = also entries/valid shown on o_dict after this edge
    typedef struct {
        logic             rst;
        logic             flush;
        logic [1:0]       wr;
        logic [DW-1:0]    d0, d1;
        int               cnt;
        logic             full, ovf;
        int               chk;
        logic [DW-1:0]    e0, e1, e2, e15;
        logic [DEPTH-1:0] vld;
    } vec_t;

    vec_t tbl [$];

    function automatic void add_row(input logic rst, input logic flush, input logic [1:0] wr,
                                    input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                    input int cnt, input logic full, input logic ovf,
                                    input int chk, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                                    input logic [DW-1:0] e2, input logic [DW-1:0] e15,
                                    input logic [DEPTH-1:0] vld);
        vec_t v;
        v.rst = rst; v.flush = flush; v.wr = wr; v.d0 = d0; v.d1 = d1;
        v.cnt = cnt; v.full = full; v.ovf = ovf; v.chk = chk;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e15 = e15; v.vld = vld;
        tbl.push_back(v);
    endfunction

    initial begin
        reset       = 1'b1;
        bus.i_flush = 1'b0;
        bus.i_wr    = '0;
        bus.i_data  = '0;
        for (int e = 0; e < DEPTH; e++) m_win[e] = '0;
        m_vld = '0;
        m_cnt = 0;
        m_ovf = 1'b0;

        //        rst  fl  wr     d0     d1     cnt full ovf chk e0   e1   e2   e15  vld
        add_row(1, 0, 2'b11, 32'h1, 32'h2, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
        add_row(1, 0, 2'b11, 32'h1, 32'h2, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
        add_row(0, 0, 2'b11, 32'hA, 32'hB, 2, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        add_row(0, 0, 2'b01, 32'hC, 32'hDD, 3, 0, 0, 1, 32'hB, 32'hA, 0, 0, 16'h0003);
        add_row(0, 0, 2'b00, 32'h0, 32'h0, 3, 0, 0, 1, 32'hC, 32'hB, 32'hA, 0, 16'h0007);
        add_row(0, 1, 2'b00, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        add_row(0, 0, 2'b00, 32'h0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
        add_row(0, 0, 2'b10, 32'h77, 32'h55, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        add_row(0, 0, 2'b00, 32'h0, 32'h0, 1, 0, 0, 1, 32'h55, 0, 0, 0, 16'h0001);
        add_row(0, 1, 2'b00, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        for (int k = 1; k <= 8; k++)
            add_row(0, 0, 2'b11, 32'(2*k-1), 32'(2*k), 2*k, (k == 8), 0, 0, 0, 0, 0, 0, 16'h0000);
        add_row(0, 0, 2'b00, 32'h0, 32'h0, 16, 1, 0, 1, 32'd16, 32'd15, 32'd14, 32'd1, 16'hFFFF);
        add_row(0, 0, 2'b11, 32'd17, 32'd18, 16, 1, 1, 0, 0, 0, 0, 0, 16'h0000);
        add_row(0, 0, 2'b00, 32'h0, 32'h0, 16, 1, 0, 1, 32'd18, 32'd17, 32'd16, 32'd3, 16'hFFFF);
        add_row(0, 1, 2'b01, 32'h99, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        add_row(0, 0, 2'b00, 32'h0, 32'h0, 1, 0, 0, 1, 32'h99, 0, 0, 0, 16'h0001);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].flush, tbl[i].wr, tbl[i].d0, tbl[i].d1);
            check($sformatf("tbl%0d_count", i), 64'(bus.o_count), 64'(tbl[i].cnt));
            check($sformatf("tbl%0d_full", i), 64'(bus.o_full), 64'(tbl[i].full));
            check($sformatf("tbl%0d_ovf", i), 64'(bus.o_ovf), 64'(tbl[i].ovf));
            if (tbl[i].chk == 1) begin
                check($sformatf("tbl%0d_valid", i), 64'(bus.o_valid), 64'(tbl[i].vld));
                if (tbl[i].vld[0])  check($sformatf("tbl%0d_e0", i), 64'(bus.o_dict[0*DW +: DW]), 64'(tbl[i].e0));
                if (tbl[i].vld[1])  check($sformatf("tbl%0d_e1", i), 64'(bus.o_dict[1*DW +: DW]), 64'(tbl[i].e1));
                if (tbl[i].vld[2])  check($sformatf("tbl%0d_e2", i), 64'(bus.o_dict[2*DW +: DW]), 64'(tbl[i].e2));
                if (tbl[i].vld[15]) check($sformatf("tbl%0d_e15", i), 64'(bus.o_dict[15*DW +: DW]), 64'(tbl[i].e15));
            end
        end

        // Reset in the middle of a stream: build up 7 entries, then reset during a dual write.
        step(0, 1, 2'b11, 32'h101, 32'h102);
        step(0, 0, 2'b11, 32'h103, 32'h104);
        step(0, 0, 2'b11, 32'h105, 32'h106);
        step(0, 0, 2'b01, 32'h107, 32'h0);
        check("mid_count7", 64'(bus.o_count), 64'(7));
        step(1, 0, 2'b11, 32'h108, 32'h109);
        check("mid_rst_count", 64'(bus.o_count), 64'(0));
        check("mid_rst_valid", 64'(bus.o_valid), 64'(0));
        step(0, 0, 2'b00, 32'h0, 32'h0);
        check("mid_after_count", 64'(bus.o_count), 64'(0));
        check("mid_after_valid", 64'(bus.o_valid), 64'(0));

        // Back-to-back overflowing writes keep o_ovf high; an idle cycle drops it.
        for (int k = 0; k < 8; k++) step(0, 0, 2'b11, 32'(k), 32'(k + 100));
        step(0, 0, 2'b01, 32'hE1, 32'h0);
        check("ovf_first", 64'(bus.o_ovf), 64'(1));
        step(0, 0, 2'b10, 32'h0, 32'hE2);
        check("ovf_second", 64'(bus.o_ovf), 64'(1));
        step(0, 0, 2'b00, 32'h0, 32'h0);
        check("ovf_drop", 64'(bus.o_ovf), 64'(0));
        step(0, 0, 2'b00, 32'h0, 32'h0);
        check("ovf_e0", 64'(bus.o_dict[0*DW +: DW]), 64'(32'hE2));
        check("ovf_e1", 64'(bus.o_dict[1*DW +: DW]), 64'(32'hE1));

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                 2'($urandom_range(0, 3)), $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dict_shift_multi.md
Name: dict_shift_multi

Overview:
- Parametrised multi-lane sliding dictionary for the Stage1 compressor datapath.
- Each cycle it accepts up to LANES new words and shifts them into a recency-ordered window of DEPTH words. Entry 0 always holds the most recent word.
- Exports the whole window flattened, plus a per-entry valid bitmap, occupancy and full/overflow status, for the parallel match comparators.
- Generalises the fixed two-writer, eight-deep dictionary to arbitrary lane count and depth, and adds flush, occupancy tracking and an optional output register stage.

Parameters:
- DATA_WIDTH, 32, width of one dictionary word.
- DEPTH, 16, number of dictionary entries. Must satisfy DEPTH >= LANES and DEPTH >= 2.
- LANES, 2, number of write lanes per cycle. Range 1..8.
- OUT_REG, 1, 1 = extra register stage on o_dict/o_valid; 0 = outputs driven directly from the window registers.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_wr  in  LANES  per-lane write enable.
- i_data  in  LANES*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_flush  in  1  synchronous dictionary clear.
- o_dict  out  DEPTH*DATA_WIDTH  entry e occupies bits [e*DATA_WIDTH +: DATA_WIDTH]; e=0 is newest.
- o_valid  out  DEPTH  bit e = entry e holds a written word.
- o_count  out  $clog2(DEPTH+1)  number of valid entries, saturating at DEPTH.
- o_full  out  1  high when o_count == DEPTH.
- o_ovf  out  1  one-cycle pulse when the current write evicted at least one valid entry.

Behaviour:
- Reset (i_reset=1 at a clock edge):
  - all window words, valid bits, o_dict, o_valid, o_count, o_full and o_ovf go to 0, including the OUT_REG stage;
  - reset overrides flush and writes in the same cycle;
  - reset mid-stream discards all contents, with no partial shift.
- Write count: n = popcount(i_wr), 0..LANES.
- Write compaction:
  - enabled lanes are packed in lane-index order;
  - the highest-indexed enabled lane becomes entry 0, the next lower enabled lane entry 1, and so on;
  - disabled lanes consume no slot.
- Shift:
  - old entry e moves to entry e+n;
  - entries with e+n >= DEPTH are discarded, and their valid bits leave with them;
  - new entries get valid=1;
  - n=0 holds the window unchanged.
- Flush:
  - i_flush=1 clears all valid bits and resets the count before the same cycle's writes are applied;
  - after flush+write with n words, exactly entries 0..n-1 are valid and o_count=n;
  - flushed data words need not be zeroed; only valid bits are architectural. o_dict for invalid entries is don't-care except after reset, where it is 0.
- Count:
  - next o_count = min(DEPTH, base + n), where base = 0 if flushing, else the current count;
  - o_full = (next count == DEPTH), registered together with the count.
- Overflow:
  - o_ovf = 1 for exactly the cycle following an edge where base + n > DEPTH;
  - flush-cycle writes never overflow, since DEPTH >= LANES.
- Latency:
  - o_count, o_full and o_ovf always update one edge after the write;
  - o_dict and o_valid update one edge after the write when OUT_REG=0, and two edges after when OUT_REG=1;
  - with OUT_REG=1, o_count and o_full lead o_dict/o_valid by one cycle (deliberate: lets the match stage pre-compute the search range).
- Data values are not interpreted; duplicate words are stored as separate entries.
- No backpressure: the block accepts writes every cycle, and o_full is informational only.
- All lanes are written in the same cycle; there is no priority between lanes beyond the ordering rule above.

Test Plan:
- Reset check (DW=32, DEPTH=16, LANES=2, OUT_REG=1): hold i_reset=1 for 2 cycles with i_wr=2'b11 -> o_valid=0, o_count=0, o_dict=0, o_full=0, o_ovf=0.
- Dual write: write i_wr=2'b11, lane0=0xA, lane1=0xB; then i_wr=2'b01, lane0=0xC -> two edges after the second write: entry0=0xC, entry1=0xB, entry2=0xA, o_valid=16'h0007, o_count=3.
- Single upper lane: i_wr=2'b10 with lane1=0x55 into an empty dictionary -> entry0=0x55, o_count=1, lane0 data ignored.
- Fill and wrap: 8 cycles of dual writes with values 1..16 (lane0 odd, lane1 even) -> o_full=1, o_count=16, entry0=16, entry15=1, o_ovf=0. A ninth dual write (17,18) -> o_ovf pulses once, entry0=18, entry15=3, o_count stays 16.
- Flush with write: from a full dictionary, assert i_flush=1 with i_wr=2'b01, lane0=0x99 -> o_count=1, o_valid=16'h0001, entry0=0x99, o_full=0, o_ovf=0.
- Reset mid-stream: assert i_reset during a dual write at o_count=7 -> next cycle o_count=0, o_valid=0, and the write is discarded.
